trig_mode_ctrl: RTL and testbench

//  Sequences single/double trigger-path selection for the muon-decay front end. Drives the

---
 rtl/trig_mode_ctrl_if.sv | 67 ++++++
 rtl/trig_mode_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_trig_mode_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_mode_ctrl_if.sv
// Bus bundle between the register bank / DAQ side and trig_mode_ctrl.
// The auto_en and dwell signals exist only when TRIG_MODE_AUTO_EN is defined.
interface trig_mode_ctrl_if #(
    parameter int unsigned CNT_W   = 32
`ifdef TRIG_MODE_AUTO_EN
    ,
    parameter int unsigned DWELL_W = 32
`endif
);
    logic             mode_req;
    logic             mode_wr;
    logic             trig_single;
    logic             trig_double;
    logic             trig_mux;
    logic             cnt_clr;
    logic             sel;
    logic             trig_out;
    logic             blank;
    logic             busy;
    logic             mode_ack;
    logic [CNT_W-1:0] cnt_single;
    logic [CNT_W-1:0] cnt_double;
`ifdef TRIG_MODE_AUTO_EN
    logic               auto_en;
    logic [DWELL_W-1:0] dwell;
`endif

    modport master (
        output mode_req,
        output mode_wr,
        output trig_single,
        output trig_double,
        output trig_mux,
        output cnt_clr,
`ifdef TRIG_MODE_AUTO_EN
        output auto_en,
        output dwell,
`endif
        input  sel,
        input  trig_out,
        input  blank,
        input  busy,
        input  mode_ack,
        input  cnt_single,
        input  cnt_double
    );

    modport slave (
        input  mode_req,
        input  mode_wr,
        input  trig_single,
        input  trig_double,
        input  trig_mux,
        input  cnt_clr,
`ifdef TRIG_MODE_AUTO_EN
        input  auto_en,
        input  dwell,
`endif
        output sel,
        output trig_out,
        output blank,
        output busy,
        output mode_ack,
        output cnt_single,
        output cnt_double
    );
endinterface

// File: rtl/trig_mode_ctrl.sv
// Single/double trigger-path select sequencer: guarded mux switching, trigger blanking
// around each switch and per-mode trigger counters. Auto-switch option: TRIG_MODE_AUTO_EN.
module trig_mode_ctrl #(
    parameter int unsigned GUARD_CYCLES = 16,
    parameter int unsigned CNT_W        = 32
`ifdef TRIG_MODE_AUTO_EN
    ,
    parameter int unsigned DWELL_W      = 32
`endif
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    trig_mode_ctrl_if.slave io_bus
);

    localparam int unsigned   GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        StActive = 2'd0,
        StBlank  = 2'd1,
        StSettle = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_sel;
    logic             w_sel_nxt;
    logic [GW-1:0]    r_cnt;
    logic [GW-1:0]    w_cnt_nxt;
    logic             r_pend_vld;
    logic             w_pend_vld_nxt;
    logic             r_pend_mode;
    logic             w_pend_mode_nxt;
    logic             r_ack;
    logic             w_ack_nxt;
    logic             r_trig_out;
    logic             r_mux_prev;
    logic [CNT_W-1:0] r_cnt_single;
    logic [CNT_W-1:0] r_cnt_double;

    logic w_active;
    logic w_activity;
    logic w_rise;
    logic w_req_vld;
    logic w_req_mode;
    logic w_auto_fire;

    assign w_active   = (r_state == StActive);
    assign w_activity = io_bus.trig_single | io_bus.trig_double;
    assign w_rise     = io_bus.trig_mux & ~r_mux_prev & w_active;

`ifdef TRIG_MODE_AUTO_EN
    localparam int unsigned DW1 = DWELL_W + 1;

    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] w_dwell_nxt;

    // r_dwell_cnt holds completed ACTIVE cycles, so the current cycle is the count plus one
    assign w_auto_fire = io_bus.auto_en && (io_bus.dwell != '0) &&
                         ((DW1'(r_dwell_cnt) + DW1'(1)) >= DW1'(io_bus.dwell));

    always_comb begin
        w_dwell_nxt = '0;
        if (w_active && (w_state_nxt == StActive) && !io_bus.mode_wr) begin
            w_dwell_nxt = (r_dwell_cnt == '1) ? r_dwell_cnt : r_dwell_cnt + DWELL_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_dwell_cnt <= '0;
        end else begin
            r_dwell_cnt <= w_dwell_nxt;
        end
    end
`else
    assign w_auto_fire = 1'b0;
`endif

    // Request source priority: external write, then the held pending slot, then auto
    always_comb begin
        w_req_vld  = 1'b0;
        w_req_mode = r_sel;
        if (io_bus.mode_wr) begin
            w_req_vld  = 1'b1;
            w_req_mode = io_bus.mode_req;
        end else if (r_pend_vld) begin
            w_req_vld  = 1'b1;
            w_req_mode = r_pend_mode;
        end else if (w_auto_fire) begin
            w_req_vld  = 1'b1;
            w_req_mode = ~r_sel;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_cnt_nxt       = r_cnt;
        w_ack_nxt       = 1'b0;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_mode_nxt = r_pend_mode;
        unique case (r_state)
            StActive: begin
                w_pend_vld_nxt = 1'b0;
                if (w_req_vld) begin
                    if (w_req_mode != r_sel) begin
                        w_state_nxt = StBlank;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_ack_nxt = 1'b1;
                    end
                end
            end
            StBlank: begin
                if (w_activity) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == GUARD_LAST) begin
                    w_state_nxt = StSettle;
                    w_sel_nxt   = ~r_sel;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + GW'(1);
                end
            end
            StSettle: begin
                if (r_cnt == GUARD_LAST) begin
                    w_state_nxt = StActive;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + GW'(1);
                end
            end
            default: begin
                w_state_nxt = StActive;
                w_cnt_nxt   = '0;
            end
        endcase
        // Writes that arrive mid-switch land in a single slot; the last one wins
        if (!w_active && io_bus.mode_wr) begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_mode_nxt = io_bus.mode_req;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= StActive;
            r_sel       <= 1'b0;
            r_cnt       <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_mode <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_mode <= w_pend_mode_nxt;
            r_ack       <= w_ack_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_trig_out <= 1'b0;
            r_mux_prev <= 1'b0;
        end else begin
            r_trig_out <= io_bus.trig_mux & w_active;
            r_mux_prev <= io_bus.trig_mux;
        end
    end

    // Counters saturate at all-ones; a clear beats an edge in the same cycle
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (io_bus.cnt_clr) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (w_rise) begin
            if (r_sel) begin
                if (r_cnt_double != '1) begin
                    r_cnt_double <= r_cnt_double + CNT_W'(1);
                end
            end else begin
                if (r_cnt_single != '1) begin
                    r_cnt_single <= r_cnt_single + CNT_W'(1);
                end
            end
        end
    end

    assign io_bus.sel        = r_sel;
    assign io_bus.trig_out   = r_trig_out;
    assign io_bus.blank      = ~w_active;
    assign io_bus.busy       = ~w_active;
    assign io_bus.mode_ack   = r_ack;
    assign io_bus.cnt_single = r_cnt_single;
    assign io_bus.cnt_double = r_cnt_double;

endmodule

// File: tb/tb_trig_mode_ctrl.sv
// Self-checking bench for trig_mode_ctrl: directed switch/blank/count scenarios plus random
// traffic against a cycle-indexed reference model. Auto-switch tests need TRIG_MODE_AUTO_EN.
module tb_trig_mode_ctrl;

    localparam int unsigned G  = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

`ifdef TRIG_MODE_AUTO_EN
    trig_mode_ctrl_if #(.CNT_W(CW), .DWELL_W(DW)) bus ();
    trig_mode_ctrl #(.GUARD_CYCLES(G), .CNT_W(CW), .DWELL_W(DW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .io_bus (bus)
    );
`else
    trig_mode_ctrl_if #(.CNT_W(CW)) bus ();
    trig_mode_ctrl #(.GUARD_CYCLES(G), .CNT_W(CW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .io_bus (bus)
    );
`endif

    int n_err    = 0;
    int n_checks = 0;

    // Reference model: switch progress tracked by absolute cycle stamps
    int          m_cyc;
    bit          m_sel;
    bit          m_in_switch;
    bit          m_toggled;
    int          m_quiet_start;
    int          m_settle_start;
    int          m_active_since;
    bit          m_pend_vld;
    bit          m_pend_mode;
    bit          m_ack;
    bit          m_trig_out;
    bit          m_prev_mux;
    logic [CW-1:0] m_cnt_s;
    logic [CW-1:0] m_cnt_d;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_sel = 0; m_in_switch = 0; m_toggled = 0;
        m_quiet_start = 0; m_settle_start = 0; m_active_since = 0;
        m_pend_vld = 0; m_pend_mode = 0; m_ack = 0; m_trig_out = 0; m_prev_mux = 0;
        m_cnt_s = '0; m_cnt_d = '0;
    endtask

    task automatic model_step();
        bit active    = !m_in_switch;
        bit want_vld  = 0;
        bit want_mode = 0;
        int c         = m_cyc;
        m_trig_out = bus.trig_mux & active;
        if (bus.cnt_clr) begin
            m_cnt_s = '0;
            m_cnt_d = '0;
        end else if (active && bus.trig_mux && !m_prev_mux) begin
            if (m_sel) m_cnt_d = sat_inc(m_cnt_d);
            else       m_cnt_s = sat_inc(m_cnt_s);
        end
        m_prev_mux = bus.trig_mux;
        m_ack = 0;
        if (active) begin
            if (bus.mode_wr) begin
                want_vld = 1; want_mode = bus.mode_req; m_active_since = c + 1;
            end else if (m_pend_vld) begin
                want_vld = 1; want_mode = m_pend_mode;
            end
`ifdef TRIG_MODE_AUTO_EN
            else if (bus.auto_en && bus.dwell != 0 && (c - m_active_since + 1) >= int'(bus.dwell)) begin
                want_vld = 1; want_mode = !m_sel;
            end
`endif
            m_pend_vld = 0;
            if (want_vld) begin
                if (want_mode != m_sel) begin
                    m_in_switch = 1; m_toggled = 0; m_quiet_start = c + 1;
                end else begin
                    m_ack = 1;
                end
            end
        end else begin
            if (bus.mode_wr) begin
                m_pend_vld = 1; m_pend_mode = bus.mode_req;
            end
            if (!m_toggled) begin
                if (bus.trig_single || bus.trig_double) m_quiet_start = c + 1;
                else if (c + 1 - m_quiet_start >= int'(G)) begin
                    m_sel = !m_sel; m_toggled = 1; m_settle_start = c + 1;
                end
            end else if (c + 1 - m_settle_start >= int'(G)) begin
                m_in_switch = 0; m_ack = 1; m_active_since = c + 1;
            end
        end
        m_cyc++;
    endtask

    task automatic check_all();
        chk("sel",        32'(bus.sel),        32'(m_sel));
        chk("blank",      32'(bus.blank),      32'(m_in_switch));
        chk("busy",       32'(bus.busy),       32'(m_in_switch));
        chk("mode_ack",   32'(bus.mode_ack),   32'(m_ack));
        chk("trig_out",   32'(bus.trig_out),   32'(m_trig_out));
        chk("cnt_single", 32'(bus.cnt_single), 32'(m_cnt_s));
        chk("cnt_double", 32'(bus.cnt_double), 32'(m_cnt_d));
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        bus.mode_wr = 1'b0;
        bus.cnt_clr = 1'b0;
    endtask

    task automatic do_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    task automatic wait_ack(input string tag);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            do_cycle();
            if (bus.mode_ack === 1'b1) seen = 1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic write_mode(input bit m);
        bus.mode_req = m;
        bus.mode_wr  = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sel"},   32'(bus.sel),        32'd0);
        chk({tag, "_blank"}, 32'(bus.blank),      32'd0);
        chk({tag, "_busy"},  32'(bus.busy),       32'd0);
        chk({tag, "_ack"},   32'(bus.mode_ack),   32'd0);
        chk({tag, "_tout"},  32'(bus.trig_out),   32'd0);
        chk({tag, "_cs"},    32'(bus.cnt_single), 32'd0);
        chk({tag, "_cd"},    32'(bus.cnt_double), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_prev;
        int toggles;
        bit last_sel;

        rstn = 1'b0;
        bus.mode_req = 0; bus.mode_wr = 0; bus.trig_single = 0; bus.trig_double = 0;
        bus.trig_mux = 0; bus.cnt_clr = 0;
`ifdef TRIG_MODE_AUTO_EN
        bus.auto_en = 1'b0;
        bus.dwell   = '0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rstn = 1'b1;

        // Switch to double with quiet inputs: blank N+1, sel N+5, ack N+9
        write_mode(1'b1);
        do_cycle();
        chk("t2_blank_n1", 32'(bus.blank), 32'd1);
        chk("t2_busy_n1",  32'(bus.busy),  32'd1);
        do_cycles(3);
        chk("t2_sel_n4", 32'(bus.sel), 32'd0);
        do_cycle();
        chk("t2_sel_n5", 32'(bus.sel), 32'd1);
        do_cycles(3);
        chk("t2_ack_n8", 32'(bus.mode_ack), 32'd0);
        do_cycle();
        chk("t2_ack_n9",   32'(bus.mode_ack), 32'd1);
        chk("t2_blank_n9", 32'(bus.blank),    32'd0);
        do_cycle();
        write_mode(1'b1);
        do_cycle();
        chk("t2_same_ack",   32'(bus.mode_ack), 32'd1);
        chk("t2_same_blank", 32'(bus.blank),    32'd0);

        // Activity during BLANK holds off the switch until 4 quiet cycles pass
        write_mode(1'b0);
        do_cycle();
        bus.trig_double = 1'b1;
        do_cycles(10);
        bus.trig_double = 1'b0;
        do_cycles(3);
        chk("t3_sel_hold", 32'(bus.sel), 32'd1);
        do_cycle();
        chk("t3_sel_sw", 32'(bus.sel), 32'd0);
        wait_ack("t3_ack");

        // Five pulses in single mode, then a clear on the sixth edge
        bus.cnt_clr = 1'b1;
        do_cycle();
        for (int i = 0; i < 5; i++) begin
            bus.trig_mux = 1'b1;
            do_cycle();
            chk("t4_tout_hi", 32'(bus.trig_out), 32'd1);
            bus.trig_mux = 1'b0;
            do_cycle();
            chk("t4_tout_lo", 32'(bus.trig_out), 32'd0);
        end
        chk("t4_cnt_s", 32'(bus.cnt_single), 32'd5);
        chk("t4_cnt_d", 32'(bus.cnt_double), 32'd0);
        bus.trig_mux = 1'b1;
        bus.cnt_clr  = 1'b1;
        do_cycle();
        chk("t4_clr_wins", 32'(bus.cnt_single), 32'd0);
        bus.trig_mux = 1'b0;
        do_cycle();

        // Write 1, then write 0 during SETTLE: ack for 1, then a full switch back
        write_mode(1'b1);
        do_cycle();
        do_cycles(4);
        write_mode(1'b0);
        do_cycle();
        wait_ack("t5_ack1");
        chk("t5_sel1", 32'(bus.sel), 32'd1);
        do_cycle();
        chk("t5_reblank", 32'(bus.blank), 32'd1);
        wait_ack("t5_ack0");
        chk("t5_sel0", 32'(bus.sel), 32'd0);

        // Saturation of the single counter
        bus.cnt_clr = 1'b1;
        do_cycle();
        for (int i = 0; i < 260; i++) begin
            bus.trig_mux = 1'b1;
            do_cycle();
            bus.trig_mux = 1'b0;
            do_cycle();
        end
        chk("sat_cnt_s", 32'(bus.cnt_single), 32'd255);
        chk("sat_cnt_d", 32'(bus.cnt_double), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus.mode_wr     = ($urandom_range(0, 11) == 0);
            bus.mode_req    = 1'($urandom_range(0, 1));
            bus.trig_single = ($urandom_range(0, 9) == 0);
            bus.trig_double = ($urandom_range(0, 9) == 0);
            bus.trig_mux    = 1'($urandom_range(0, 1));
            bus.cnt_clr     = ($urandom_range(0, 199) == 0);
            do_cycle();
        end
        bus.trig_single = 1'b0;
        bus.trig_double = 1'b0;
        bus.trig_mux    = 1'b0;

        // Asynchronous reset in the middle of a switch
        write_mode(!m_sel);
        do_cycle();
        do_cycle();
        bus.trig_mux = 1'b1;
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        bus.trig_mux = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        do_cycles(3);

`ifdef TRIG_MODE_AUTO_EN
        // Auto toggling: 20 ACTIVE + 4 BLANK + 4 SETTLE cycles per period
        bus.dwell   = DW'(20);
        bus.auto_en = 1'b1;
        last_sel = m_sel;
        toggles  = 0;
        t_prev   = 0;
        for (int i = 0; i < 200 && toggles < 4; i++) begin
            bus.trig_mux = 1'($urandom_range(0, 1));
            do_cycle();
            if (bus.sel !== last_sel) begin
                if (toggles >= 1) chk("auto_period", 32'(m_cyc - t_prev), 32'd28);
                t_prev   = m_cyc;
                last_sel = bus.sel;
                toggles++;
            end
        end
        chk("auto_toggles", 32'(toggles), 32'd4);
        bus.auto_en  = 1'b0;
        bus.trig_mux = 1'b0;
        do_cycles(40);
`else
        t_prev   = 0;
        toggles  = 0;
        last_sel = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
